haar_stage_evaluator: RTL and testbench
=======================================

Name: haar_stage_evaluator

Overview:
- Consumes the per-stage database words produced by the stage memory block.
- Per stage, reads the feature count and the stage threshold, then accumulates that many signed feature results from the feature evaluator.
- Compares the sum against the stage threshold.
- Walks all stages of the cascade for one candidate window and reports face / no-face, with early reject on the first failing stage.

Parameters:
- NUM_STAGES, 10: stages in the cascade.
- DATA_WIDTH, 16: database word and feature value width.
- ACC_WIDTH, 24: signed accumulator width.
- STAGE_IDX_WIDTH, 5: width of o_stage_index.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- i_start, input, 1: one-cycle pulse that begins evaluation of a window; ignored unless idle.
- o_ren_database, output, 1: read strobe to the stage memory ROM.
- o_ren_index, output, 1: advance strobe to the stage memory address counter.
- i_db_data, input, DATA_WIDTH: stage memory read data.
- o_feature_req, output, 1: one-cycle pulse requesting the next feature result.
- i_feature_valid, input, 1: feature result valid.
- i_feature_value, input, DATA_WIDTH: signed feature result.
- o_busy, output, 1: high from accepted start until done.
- o_done, output, 1: one-cycle pulse when the window verdict is final.
- o_face_detected, output, 1: verdict, valid with o_done and held until the next start.
- o_stage_index, output, STAGE_IDX_WIDTH: current stage, or the failing stage after a reject.

Behaviour:
Database layout and read protocol:
- The stage memory holds 2*NUM_STAGES words. For stage s:
  - word 2s = feature count, unsigned, 0..255.
  - word 2s+1 = stage threshold, signed two's complement.
- The stage memory counter wraps to 0 after its last word, so a complete pass of 2*NUM_STAGES index advances returns it to word 0.
- Read protocol:
  - Cycle N: o_ren_database=1.
  - Cycle N+1: i_db_data is valid and is captured; o_ren_index=1 in the same cycle.
- Exactly one index advance per word read; never both strobes in one cycle.

Reset:
- State IDLE.
- All outputs 0.
- Accumulator, word counter, feature counter and stage index all 0.

States:
- IDLE: o_busy=0. On i_start go to RD_CNT_REQ, set o_busy=1, clear o_face_detected, clear stage index.
- RD_CNT_REQ: o_ren_database=1, then go to RD_CNT.
- RD_CNT: latch the feature count, pulse o_ren_index, then go to RD_THR_REQ.
- RD_THR_REQ: o_ren_database=1, then go to RD_THR.
- RD_THR: latch the threshold, pulse o_ren_index, clear the accumulator. Go to COMPARE if the count is 0, else go to FEAT_REQ.
- FEAT_REQ: pulse o_feature_req, then go to FEAT_WAIT.
- FEAT_WAIT:
  - On i_feature_valid, add the sign-extended value to the accumulator and decrement the remaining count.
  - If the remaining count becomes 0, go to COMPARE, else go to FEAT_REQ.
  - No timeout; waiting is unbounded.
- COMPARE: signed comparison acc >= sign-extended threshold.
  - Pass and stage = NUM_STAGES-1: set o_face_detected=1, go to DONE.
  - Pass otherwise: increment stage index, go to RD_CNT_REQ.
  - Fail: o_face_detected=0, go to SKIP.
- SKIP:
  - Pulse o_ren_index once per cycle, with no read, until the total index advances for this window reach 2*NUM_STAGES.
  - Then go to DONE. This realigns the stage memory to word 0.
- DONE: o_done=1 for one cycle, then go to IDLE. o_busy drops in the same cycle o_done is high.

Arithmetic:
- The accumulator does not saturate; ACC_WIDTH is sized for 255 * full-scale values.
- The threshold is sign-extended to ACC_WIDTH before comparison.

Boundary conditions:
- Equality passes.
- i_start while busy is ignored.
- i_feature_valid outside FEAT_WAIT is ignored.
- Reset asserted mid-window returns to IDLE immediately. The stage memory is reset by the same signal, so address alignment is preserved.

Latency:
- Minimum per stage with count 0: 5 cycles.
- Each feature adds 2 cycles plus the feature-valid wait.

Decomposition:
- Shared package holds:
  - State encoding enum.
  - Database word offsets: WORD_FEATURE_COUNT=0, WORD_THRESHOLD=1, WORDS_PER_STAGE=2.
  - Default DATA_WIDTH and ACC_WIDTH.
- One natural sub-module, haar_stage_accumulator: signed accumulate, clear, and compare. The FSM stays in the top module.

Test Plan:
1. Reset mid-FEAT_WAIT -> all outputs 0 immediately; state IDLE; the next window reads from word 0.
2. 2 stages, counts {2,1}, thresholds {10,-5}, features {6,4},{-5} -> both pass; o_done with o_face_detected=1; exactly 4 o_ren_index pulses total.
3. 3 stages, stage 0 count 1, threshold 100, feature 99 -> fail; o_stage_index=0; SKIP issues 4 index-only pulses (6 total); o_face_detected=0.
4. Stage with count 0 and threshold 0 -> passes (0>=0) with no o_feature_req; a threshold of 1 fails.
5. i_start pulsed during busy, stray i_feature_valid during RD_THR -> no effect; verdict unchanged versus a clean run.
6. Feature values of -32768 repeated 255 times against threshold -32768 -> sign-extended sum compares correctly (fail at stage 0, no overflow wrap).

Source files
------------

// File: rtl/haar_stage_evaluator_pkg.sv
// Shared definitions for the Haar cascade stage evaluator: FSM states,
// stage-memory word layout and default datapath widths.
package haar_stage_evaluator_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_CNT_REQ,
    ST_RD_CNT,
    ST_RD_THR_REQ,
    ST_RD_THR,
    ST_FEAT_REQ,
    ST_FEAT_WAIT,
    ST_COMPARE,
    ST_SKIP,
    ST_DONE
  } state_t;

  // Per-stage word layout in the stage memory
  localparam int unsigned WORD_FEATURE_COUNT = 0;
  localparam int unsigned WORD_THRESHOLD     = 1;
  localparam int unsigned WORDS_PER_STAGE    = 2;

  // Feature count is an 8-bit unsigned field of the count word
  localparam int unsigned COUNT_WIDTH = 8;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ACC_WIDTH  = 24;

endpackage

// File: rtl/haar_stage_evaluator_if.sv
// Stage-memory read bus and feature-evaluator handshake.
// master = stage evaluator side, slave = memory / feature evaluator side.
interface haar_stage_evaluator_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  o_ren_database;
  logic                  o_ren_index;
  logic [DATA_WIDTH-1:0] i_db_data;
  logic                  o_feature_req;
  logic                  i_feature_valid;
  logic [DATA_WIDTH-1:0] i_feature_value;

  modport master (
    output o_ren_database,
    output o_ren_index,
    input  i_db_data,
    output o_feature_req,
    input  i_feature_valid,
    input  i_feature_value
  );

  modport slave (
    input  o_ren_database,
    input  o_ren_index,
    output i_db_data,
    input  o_feature_req,
    output i_feature_valid,
    output i_feature_value
  );
endinterface

// File: rtl/haar_stage_evaluator_accumulator.sv
// Signed feature accumulator with clear and threshold comparison.
// pass is combinational: acc >= sign-extended threshold.
module haar_stage_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  pass
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] value_ext;
  logic [ACC_WIDTH-1:0] threshold_ext;

  // Sign-extend feature value and threshold to the accumulator width
  always_comb begin
    value_ext     = {{(ACC_WIDTH-DATA_WIDTH){value[DATA_WIDTH-1]}}, value};
    threshold_ext = {{(ACC_WIDTH-DATA_WIDTH){threshold[DATA_WIDTH-1]}}, threshold};
    pass          = $signed(acc) >= $signed(threshold_ext);
  end

  // Accumulator register; clear wins over add, no saturation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + value_ext;
    end
  end

endmodule

// File: rtl/haar_stage_evaluator.sv
// Haar cascade stage evaluator: walks all stages for one window, reading
// count/threshold per stage, accumulating feature results and early-rejecting
// on the first failing stage. A reject skips the remaining stage-memory words
// so the memory address counter is back at word 0 for the next window.
module haar_stage_evaluator
  import haar_stage_evaluator_pkg::*;
#(
  parameter int NUM_STAGES      = 10,
  parameter int DATA_WIDTH      = 16,
  parameter int ACC_WIDTH       = 24,
  parameter int STAGE_IDX_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  haar_stage_evaluator_if.master     bus,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_face_detected,
  output logic [STAGE_IDX_WIDTH-1:0] o_stage_index
);

  localparam int unsigned TOTAL_WORDS = NUM_STAGES * WORDS_PER_STAGE;
  localparam int unsigned WCNT_WIDTH  = $clog2(TOTAL_WORDS + 1);

  state_t state, state_nx;

  logic [WCNT_WIDTH-1:0]      word_cnt;
  logic [COUNT_WIDTH-1:0]     feat_remaining;
  logic [DATA_WIDTH-1:0]      threshold;
  logic [STAGE_IDX_WIDTH-1:0] stage_idx;
  logic                       face;

  logic ren_database;
  logic ren_index;
  logic feature_req;
  logic acc_clear;
  logic acc_add;
  logic acc_pass;
  logic last_feature;
  logic last_stage;

  assign last_feature = (feat_remaining == COUNT_WIDTH'(1));
  assign last_stage   = (stage_idx == STAGE_IDX_WIDTH'(NUM_STAGES - 1));

  haar_stage_accumulator #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .clear     (acc_clear),
    .add_en    (acc_add),
    .value     (bus.i_feature_value),
    .threshold (threshold),
    .pass      (acc_pass)
  );

  // Next-state and strobe decode
  always_comb begin
    state_nx     = state;
    ren_database = 1'b0;
    ren_index    = 1'b0;
    feature_req  = 1'b0;
    acc_clear    = 1'b0;
    acc_add      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nx = ST_RD_CNT_REQ;
      end
      ST_RD_CNT_REQ: begin
        ren_database = 1'b1;
        state_nx     = ST_RD_CNT;
      end
      ST_RD_CNT: begin
        ren_index = 1'b1;
        state_nx  = ST_RD_THR_REQ;
      end
      ST_RD_THR_REQ: begin
        ren_database = 1'b1;
        state_nx     = ST_RD_THR;
      end
      ST_RD_THR: begin
        ren_index = 1'b1;
        acc_clear = 1'b1;
        state_nx  = (feat_remaining == '0) ? ST_COMPARE : ST_FEAT_REQ;
      end
      ST_FEAT_REQ: begin
        feature_req = 1'b1;
        state_nx    = ST_FEAT_WAIT;
      end
      ST_FEAT_WAIT: begin
        if (bus.i_feature_valid) begin
          acc_add  = 1'b1;
          state_nx = last_feature ? ST_COMPARE : ST_FEAT_REQ;
        end
      end
      ST_COMPARE: begin
        if (acc_pass) state_nx = last_stage ? ST_DONE : ST_RD_CNT_REQ;
        else          state_nx = ST_SKIP;
      end
      ST_SKIP: begin
        // A reject on the last stage has already consumed every word,
        // so SKIP may legitimately issue no advance at all.
        if (word_cnt == WCNT_WIDTH'(TOTAL_WORDS)) begin
          state_nx = ST_DONE;
        end else begin
          ren_index = 1'b1;
          if (word_cnt == WCNT_WIDTH'(TOTAL_WORDS - 1)) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register and per-window datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      word_cnt       <= '0;
      feat_remaining <= '0;
      threshold      <= '0;
      stage_idx      <= '0;
      face           <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            face      <= 1'b0;
            stage_idx <= '0;
            word_cnt  <= '0;
          end
        end
        ST_RD_CNT: begin
          feat_remaining <= bus.i_db_data[COUNT_WIDTH-1:0];
        end
        ST_RD_THR: begin
          threshold <= bus.i_db_data;
        end
        ST_FEAT_WAIT: begin
          if (bus.i_feature_valid) feat_remaining <= feat_remaining - COUNT_WIDTH'(1);
        end
        ST_COMPARE: begin
          if (acc_pass) begin
            if (last_stage) face      <= 1'b1;
            else            stage_idx <= stage_idx + STAGE_IDX_WIDTH'(1);
          end else begin
            face <= 1'b0;
          end
        end
        default: ;
      endcase
      if (ren_index) word_cnt <= word_cnt + WCNT_WIDTH'(1);
    end
  end

  assign bus.o_ren_database = ren_database;
  assign bus.o_ren_index    = ren_index;
  assign bus.o_feature_req  = feature_req;
  assign o_busy             = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done             = (state == ST_DONE);
  assign o_face_detected    = face;
  assign o_stage_index      = stage_idx;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Directed self-checking bench for haar_stage_evaluator (3-stage cascade):
// behavioural stage memory and feature responder, scoreboard of verdicts.
module tb_haar_stage_evaluator;

  localparam int NS = 3;
  localparam int BUDGET = 4000;

  typedef struct {
    logic       face;
    logic [4:0] stage;
    int         idx;
    int         reqs;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic stray;
  logic busy, done, face;
  logic [4:0] stage_index;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  haar_stage_evaluator_if #(.DATA_WIDTH(16)) bus_if ();

  haar_stage_evaluator #(
    .NUM_STAGES      (NS),
    .DATA_WIDTH      (16),
    .ACC_WIDTH       (24),
    .STAGE_IDX_WIDTH (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (start),
    .bus             (bus_if),
    .o_busy          (busy),
    .o_done          (done),
    .o_face_detected (face),
    .o_stage_index   (stage_index)
  );

  always #5 clk = ~clk;

  // Stage memory model: registered read, wrapping address counter
  logic [15:0] rom [0:2*NS-1];
  logic [2:0]  addr;
  logic [15:0] db_data;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      addr    <= '0;
      db_data <= '0;
    end else begin
      if (bus_if.o_ren_database) db_data <= rom[addr];
      if (bus_if.o_ren_index) addr <= (addr == 3'(2*NS-1)) ? 3'd0 : addr + 3'd1;
    end
  end

  // Feature responder: answers each request after resp_delay cycles
  logic [15:0] feat_mem [0:1023];
  logic [9:0]  feat_rd = '0;
  int          resp_delay;
  int          resp_cnt;
  logic        resp_pending;
  logic        resp_valid;
  logic [15:0] resp_value = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_pending <= 1'b0;
      resp_cnt     <= 0;
    end else begin
      resp_valid <= 1'b0;
      if (bus_if.o_feature_req) begin
        if (resp_delay == 0) begin
          resp_valid <= 1'b1;
          resp_value <= feat_mem[feat_rd];
          feat_rd    <= feat_rd + 10'd1;
        end else begin
          resp_pending <= 1'b1;
          resp_cnt     <= resp_delay;
        end
      end else if (resp_pending) begin
        if (resp_cnt == 1) begin
          resp_pending <= 1'b0;
          resp_valid   <= 1'b1;
          resp_value   <= feat_mem[feat_rd];
          feat_rd      <= feat_rd + 10'd1;
        end
        resp_cnt <= resp_cnt - 1;
      end
    end
  end

  assign bus_if.i_db_data       = db_data;
  assign bus_if.i_feature_valid = resp_valid | stray;
  assign bus_if.i_feature_value = resp_value;

  // Free-running strobe counters
  int idx_cnt = 0, req_cnt = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (bus_if.o_ren_index) idx_cnt <= idx_cnt + 1;
    if (bus_if.o_feature_req) req_cnt <= req_cnt + 1;
    if (bus_if.o_ren_index && bus_if.o_ren_database) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_stage(input int s, input int cnt, input logic [15:0] thr);
    rom[2*s]   = 16'(cnt);
    rom[2*s+1] = thr;
  endtask

  task automatic put_feat(input int k, input logic [15:0] v);
    feat_mem[10'(int'(feat_rd) + k)] = v;
  endtask

  task automatic load_cfg_a();
    set_stage(0, 2, 16'd10);
    set_stage(1, 1, -16'sd5);
    set_stage(2, 0, 16'd0);
    put_feat(0, 16'd6);
    put_feat(1, 16'd4);
    put_feat(2, -16'sd5);
  endtask

  task automatic run_window(input logic e_face, input logic [4:0] e_stage, input int e_idx,
                            input int e_reqs, input int e_lat, input bit disturb,
                            input string tag);
    exp_t e;
    int i0, r0, cycles, nidx, nreq;
    bit seen;
    e.face = e_face; e.stage = e_stage; e.idx = e_idx; e.reqs = e_reqs; e.lat = e_lat;
    sb.push_back(e);
    i0 = idx_cnt; r0 = req_cnt; nidx = 0; nreq = 0; seen = 0; cycles = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int c = 1; c <= BUDGET; c++) begin
      if (done) begin seen = 1'b1; cycles = c; break; end
      start = 1'b0; stray = 1'b0;
      if (disturb) begin
        if (bus_if.o_ren_index) begin
          nidx++;
          if (nidx == 2) begin start = 1'b1; stray = 1'b1; end
        end
        if (bus_if.o_feature_req) begin
          nreq++;
          if (nreq == 1) stray = 1'b1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; stray = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      chk({tag, "_face"}, 32'(face), 32'(e.face));
      chk({tag, "_stage"}, 32'(stage_index), 32'(e.stage));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_idx_pulses"}, 32'(idx_cnt - i0), 32'(e.idx));
      chk({tag, "_feat_reqs"}, 32'(req_cnt - r0), 32'(e.reqs));
      chk({tag, "_addr_realign"}, 32'(addr), 32'd0);
      if (e.lat >= 0) chk({tag, "_latency"}, 32'(cycles), 32'(e.lat));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_face_hold"}, 32'(face), 32'(e.face));
    end else begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; stray = 1'b0; resp_delay = 0;
    for (int i = 0; i < 1024; i++) feat_mem[i] = '0;
    for (int s = 0; s < NS; s++) set_stage(s, 0, 16'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_face", 32'(face), 32'd0);
    chk("rst_stage", 32'(stage_index), 32'd0);
    chk("rst_strobes", 32'({bus_if.o_ren_database, bus_if.o_ren_index, bus_if.o_feature_req}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset while waiting for a feature in stage 1
    set_stage(0, 0, 16'd0);
    set_stage(1, 2, 16'd0);
    set_stage(2, 0, 16'd0);
    resp_delay = 1000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus_if.o_feature_req) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("t1_reached_feat", 32'(found), 32'd1);
    @(negedge clk);
    chk("t1_stage_before", 32'(stage_index), 32'd1);
    chk("t1_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t1_busy_rst", 32'(busy), 32'd0);
    chk("t1_done_rst", 32'(done), 32'd0);
    chk("t1_face_rst", 32'(face), 32'd0);
    chk("t1_stage_rst", 32'(stage_index), 32'd0);
    chk("t1_strobes_rst", 32'({bus_if.o_ren_database, bus_if.o_ren_index, bus_if.o_feature_req}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp_delay = 0;
    load_cfg_a();
    run_window(1'b1, 5'd2, 6, 3, -1, 1'b0, "t1_after");

    // All stages pass, equality at stages 0/1/2
    load_cfg_a();
    resp_delay = 2;
    run_window(1'b1, 5'd2, 6, 3, -1, 1'b0, "t2");
    resp_delay = 0;

    // Stage 0 rejects, SKIP realigns with 4 index-only advances
    set_stage(0, 1, 16'd100);
    set_stage(1, 7, 16'd0);
    set_stage(2, 3, 16'd0);
    put_feat(0, 16'd99);
    run_window(1'b0, 5'd0, 6, 1, 10 + 2, 1'b0, "t3");

    // Empty stages: 0 >= 0 passes in 5 cycles each
    for (int s = 0; s < NS; s++) set_stage(s, 0, 16'd0);
    run_window(1'b1, 5'd2, 6, 0, 16, 1'b0, "t4_zero");
    // Threshold 1 on the last empty stage fails with no words left to skip
    set_stage(2, 0, 16'd1);
    run_window(1'b0, 5'd2, 6, 0, 17, 1'b0, "t4_one");

    // Start while busy and stray valids outside FEAT_WAIT
    load_cfg_a();
    run_window(1'b1, 5'd2, 6, 3, -1, 1'b1, "t5");

    // 255 x -32768 against -32768: large negative sum must not wrap
    set_stage(0, 255, 16'h8000);
    set_stage(1, 0, 16'd0);
    set_stage(2, 0, 16'd0);
    for (int k = 0; k < 255; k++) put_feat(k, 16'h8000);
    run_window(1'b0, 5'd0, 6, 255, -1, 1'b0, "t6");

    chk("strobe_overlap", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
